// File: rtl/ctc_counter_timer_if.sv
// I/O bus port of the two-channel counter/timer: chip-select, strobes,
// register offset, write data and the combinational read data.
interface ctc_counter_timer_if;
    logic        CTC_ctrl;
    logic        IO_read;
    logic        IO_write;
    logic [3:0]  Address;
    logic [15:0] Write_data;
    logic [15:0] Read_data;

    modport master (
        output CTC_ctrl, IO_read, IO_write, Address, Write_data,
        input  Read_data
    );

    modport slave (
        input  CTC_ctrl, IO_read, IO_write, Address, Write_data,
        output Read_data
    );
endinterface

// File: rtl/ctc_counter_timer.sv
// Two-channel 16-bit counter/timer with sticky done flags and terminal-count pulses.
// Define CTC_COUNTER_MODE_EN to support external-pulse counter mode on pulse0/pulse1.
module ctc_counter_timer (
    input  logic                  clock,
    input  logic                  reset,
    ctc_counter_timer_if.slave    bus,
    input  logic                  pulse0,
    input  logic                  pulse1,
    output logic                  ctc_out0,
    output logic                  ctc_out1
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    logic             wr_en;
    logic             rd_en;
    logic [1:0]       pulse_in;
    logic [1:0]       rise;
    logic             ctr_wdata;
    logic [1:0][15:0] status_w;
    logic [1:0][15:0] count_w;
    logic [1:0]       out_w;
    logic             unused_addr;

    assign wr_en       = bus.CTC_ctrl & bus.IO_write;
    assign rd_en       = bus.CTC_ctrl & bus.IO_read;
    assign pulse_in    = {pulse1, pulse0};
    assign unused_addr = bus.Address[3] ^ bus.Address[0];

`ifdef CTC_COUNTER_MODE_EN
    logic [1:0] sync_p0, sync_p1, hist_p2, rise_p3;

    // Two-flop synchronizer, history flop, then a registered one-cycle rise pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            hist_p2 <= '0;
            rise_p3 <= '0;
        end else begin
            sync_p0 <= pulse_in;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
            rise_p3 <= sync_p1 & ~hist_p2;
        end
    end

    assign rise      = rise_p3;
    assign ctr_wdata = bus.Write_data[0];
`else
    logic unused_pulse;

    assign unused_pulse = ^pulse_in;
    assign rise         = 2'b00;
    assign ctr_wdata    = 1'b0;
`endif

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t      state_q, state_d;
        logic [15:0] count_q, count_d, init_q;
        logic        ctr_q, rpt_q, done_q, done_d, out_q;
        logic        sel_ch, mode_wr, init_wr, status_rd, tick, terminal;

        assign sel_ch    = (bus.Address[1] == 1'(c));
        assign mode_wr   = wr_en & sel_ch & ~bus.Address[2];
        assign init_wr   = wr_en & sel_ch &  bus.Address[2];
        assign status_rd = rd_en & sel_ch & ~bus.Address[2];
        assign tick      = (state_q == ST_RUN) & (ctr_q ? rise[c] : 1'b1);
        // A register write to this channel swallows a coincident terminal event.
        assign terminal  = tick & (count_q == 16'd1) & ~(mode_wr | init_wr);

        always_comb begin
            state_d = state_q;
            count_d = count_q;
            done_d  = done_q;
            if (status_rd) done_d = 1'b0;
            if (mode_wr) begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end else if (init_wr) begin
                count_d = bus.Write_data;
                state_d = (bus.Write_data != 16'd0) ? ST_RUN : ST_IDLE;
            end else if (tick) begin
                if (count_q == 16'd1) begin
                    done_d = 1'b1;
                    if (rpt_q) begin
                        count_d = init_q;
                    end else begin
                        count_d = 16'd0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q - 16'd1;
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state_q <= ST_IDLE;
                count_q <= 16'd0;
                init_q  <= 16'd0;
                ctr_q   <= 1'b0;
                rpt_q   <= 1'b0;
                done_q  <= 1'b0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                done_q  <= done_d;
                out_q   <= terminal;
                if (mode_wr) begin
                    ctr_q <= ctr_wdata;
                    rpt_q <= bus.Write_data[1];
                end
                if (init_wr) init_q <= bus.Write_data;
            end
        end

        assign status_w[c] = {14'd0, (state_q == ST_RUN), done_q};
        assign count_w[c]  = count_q;
        assign out_w[c]    = out_q;
    end

    always_comb begin
        bus.Read_data = 16'h0000;
        if (rd_en) begin
            case (bus.Address[2:1])
                2'b00:   bus.Read_data = status_w[0];
                2'b01:   bus.Read_data = status_w[1];
                2'b10:   bus.Read_data = count_w[0];
                default: bus.Read_data = count_w[1];
            endcase
        end
    end

    assign ctc_out0 = out_w[0];
    assign ctc_out1 = out_w[1];

endmodule

// File: tb/tb_ctc_counter_timer.sv
// Self-checking bench for ctc_counter_timer: vector table plus hand-written
// multi-cycle sequences, with expected outputs queued on a scoreboard.
module tb_ctc_counter_timer;
    logic clock = 1'b0;
    logic reset;
    logic pulse0, pulse1;
    logic ctc_out0, ctc_out1;

    ctc_counter_timer_if bus ();

    ctc_counter_timer dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .pulse0   (pulse0),
        .pulse1   (pulse1),
        .ctc_out0 (ctc_out0),
        .ctc_out1 (ctc_out1)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [17:0] val;
    } exp_t;

    typedef struct {
        string       name;
        bit          ctrl;
        bit          rd;
        bit          wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        bit          exp_o0;
        bit          exp_o1;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(string name, bit ctrl, bit rd, bit wr, logic [3:0] addr,
                                logic [15:0] wdata, logic [15:0] exp_rd, bit o0, bit o1);
        vec_t v;
        v.name = name; v.ctrl = ctrl; v.rd = rd; v.wr = wr; v.addr = addr;
        v.wdata = wdata; v.exp_rd = exp_rd; v.exp_o0 = o0; v.exp_o1 = o1;
        vecs.push_back(v);
    endfunction

    task automatic drive(bit ctrl, bit rd, bit wr, logic [3:0] addr, logic [15:0] wdata);
        @(negedge clock);
        bus.CTC_ctrl   = ctrl;
        bus.IO_read    = rd;
        bus.IO_write   = wr;
        bus.Address    = addr;
        bus.Write_data = wdata;
    endtask

    task automatic expect_out(string name, logic [15:0] rd, bit o0, bit o1);
        exp_t e;
        e.name = name;
        e.val  = {rd, o0, o1};
        sb_q.push_back(e);
    endtask

    task automatic sample();
        exp_t        e;
        logic [17:0] act;
        #1;
        act = {bus.Read_data, ctc_out0, ctc_out1};
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got rd=%h out0=%b out1=%b, nothing expected",
                     act[17:2], act[1], act[0]);
        end else begin
            e = sb_q.pop_front();
            if (act !== e.val) begin
                failures++;
                $display("FAIL %s: got rd=%h out0=%b out1=%b, expected rd=%h out0=%b out1=%b",
                         e.name, act[17:2], act[1], act[0], e.val[17:2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic cycle(string name, bit ctrl, bit rd, bit wr, logic [3:0] addr,
                         logic [15:0] wdata, logic [15:0] exp_rd, bit o0, bit o1);
        drive(ctrl, rd, wr, addr, wdata);
        expect_out(name, exp_rd, o0, o1);
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pulse0 = 1'b0; pulse1 = 1'b0;
        bus.CTC_ctrl = 1'b0; bus.IO_read = 1'b0; bus.IO_write = 1'b0;
        bus.Address = 4'h0; bus.Write_data = 16'h0000;

        // Reset state
        add("rst_st0",  1, 1, 0, 4'h0, 16'd0, 16'h0000, 0, 0);
        add("rst_st1",  1, 1, 0, 4'h2, 16'd0, 16'h0000, 0, 0);
        add("rst_cnt0", 1, 1, 0, 4'h4, 16'd0, 16'h0000, 0, 0);
        add("rst_cnt1", 1, 1, 0, 4'h6, 16'd0, 16'h0000, 0, 0);
        // ch0 one-shot timer, INIT = 5
        add("t0_mode",  1, 0, 1, 4'h0, 16'd0, 16'h0000, 0, 0);
        add("t0_init",  1, 0, 1, 4'h4, 16'd5, 16'h0000, 0, 0);
        add("t0_c5",    1, 1, 0, 4'h4, 16'd0, 16'd5,    0, 0);
        add("t0_c4",    1, 1, 0, 4'h4, 16'd0, 16'd4,    0, 0);
        add("t0_nocs",  0, 1, 0, 4'h4, 16'd0, 16'h0000, 0, 0);
        add("t0_c2",    1, 1, 0, 4'h4, 16'd0, 16'd2,    0, 0);
        add("t0_c1",    1, 1, 0, 4'h4, 16'd0, 16'd1,    0, 0);
        add("t0_done",  1, 1, 0, 4'h0, 16'd0, 16'h0001, 1, 0);
        add("t0_clr",   1, 1, 0, 4'h0, 16'd0, 16'h0000, 0, 0);
        add("t0_c0",    1, 1, 0, 4'h4, 16'd0, 16'd0,    0, 0);
        // ch1 auto-repeat, INIT = 3
        add("r1_mode",  1, 0, 1, 4'h2, 16'd2, 16'h0000, 0, 0);
        add("r1_init",  1, 0, 1, 4'h6, 16'd3, 16'h0000, 0, 0);
        add("r1_k0",    1, 1, 0, 4'h6, 16'd0, 16'd3,    0, 0);
        add("r1_k1",    1, 1, 0, 4'h6, 16'd0, 16'd2,    0, 0);
        add("r1_k2",    1, 1, 0, 4'h6, 16'd0, 16'd1,    0, 0);
        add("r1_k3",    1, 1, 0, 4'h6, 16'd0, 16'd3,    0, 1);
        add("r1_st_a",  1, 1, 0, 4'h2, 16'd0, 16'h0003, 0, 0);
        add("r1_st_b",  1, 1, 0, 4'h2, 16'd0, 16'h0002, 0, 0);
        add("r1_k6",    1, 1, 0, 4'h6, 16'd0, 16'd3,    0, 1);
        add("r1_k7",    1, 1, 0, 4'h6, 16'd0, 16'd2,    0, 0);
        add("r1_stop",  1, 0, 1, 4'h2, 16'd0, 16'h0000, 0, 0);
        add("r1_st_c",  1, 1, 0, 4'h2, 16'd0, 16'h0000, 0, 0);
        add("r1_hold",  1, 1, 0, 4'h6, 16'd0, 16'd1,    0, 0);

        repeat (2) @(negedge clock);
        reset = 1'b0;

        foreach (vecs[i])
            cycle(vecs[i].name, vecs[i].ctrl, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_o0, vecs[i].exp_o1);

        // INIT rewrite on the terminal cycle suppresses the terminal event
        cycle("ab_init1", 1, 0, 1, 4'h4, 16'd1, 16'h0000, 0, 0);
        cycle("ab_init7", 1, 0, 1, 4'h4, 16'd7, 16'h0000, 0, 0);
        cycle("ab_cnt",   1, 1, 0, 4'h4, 16'd0, 16'd7,    0, 0);
        cycle("ab_st",    1, 1, 0, 4'h0, 16'd0, 16'h0002, 0, 0);
        cycle("ab_stop",  1, 0, 1, 4'h0, 16'd0, 16'h0000, 0, 0);

        // Terminal set wins over a coincident STATUS read-clear
        cycle("rc_mode",  1, 0, 1, 4'h0, 16'd2, 16'h0000, 0, 0);
        cycle("rc_init",  1, 0, 1, 4'h4, 16'd2, 16'h0000, 0, 0);
        cycle("rc_k0",    0, 0, 0, 4'h0, 16'd0, 16'h0000, 0, 0);
        cycle("rc_k1",    0, 0, 0, 4'h0, 16'd0, 16'h0000, 0, 0);
        cycle("rc_k2",    0, 0, 0, 4'h0, 16'd0, 16'h0000, 1, 0);
        cycle("rc_st_a",  1, 1, 0, 4'h0, 16'd0, 16'h0003, 0, 0);
        cycle("rc_st_b",  1, 1, 0, 4'h0, 16'd0, 16'h0003, 1, 0);
        cycle("rc_st_c",  1, 1, 0, 4'h0, 16'd0, 16'h0002, 0, 0);
        cycle("rc_stop",  1, 0, 1, 4'h0, 16'd0, 16'h0000, 1, 0);

        // Reset mid-count with ch1 pulsing every cycle
        cycle("rs_mode1", 1, 0, 1, 4'h2, 16'd2,   16'h0000, 0, 0);
        cycle("rs_init1", 1, 0, 1, 4'h6, 16'd1,   16'h0000, 0, 0);
        cycle("rs_init0", 1, 0, 1, 4'h4, 16'd200, 16'h0000, 0, 0);
        for (int i = 0; i < 100; i++) drive(0, 0, 0, 4'h0, 16'd0);
        cycle("rs_c100",  1, 1, 0, 4'h4, 16'd0, 16'd100, 0, 1);
        reset = 1'b1;
        expect_out("rs_async", 16'h0000, 0, 0);
        sample();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 4'h0, 16'd0);
        cycle("rs_cnt0",  1, 1, 0, 4'h4, 16'd0, 16'h0000, 0, 0);
        cycle("rs_st0",   1, 1, 0, 4'h0, 16'd0, 16'h0000, 0, 0);
        cycle("rs_cnt1",  1, 1, 0, 4'h6, 16'd0, 16'h0000, 0, 0);
        cycle("rs_st1",   1, 1, 0, 4'h2, 16'd0, 16'h0000, 0, 0);

`ifdef CTC_COUNTER_MODE_EN
        // Counter mode: two 4-cycle pulses, tick 3 edges after first high sample
        cycle("cm_mode",  1, 0, 1, 4'h0, 16'd1, 16'h0000, 0, 0);
        cycle("cm_init",  1, 0, 1, 4'h4, 16'd2, 16'h0000, 0, 0);
        for (int j = 0; j < 16; j++) begin
            drive(1, 1, 0, 4'h4, 16'd0);
            pulse0 = ((j % 8) < 4);
            expect_out("cm_count", (j < 4) ? 16'd2 : ((j < 12) ? 16'd1 : 16'd0), (j == 12), 0);
            sample();
        end
        cycle("cm_done",  1, 1, 0, 4'h0, 16'd0, 16'h0001, 0, 0);
`endif

        drive(0, 0, 0, 4'h0, 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
